// File: rtl/idli_nibw_m.sv
// idli_nibw_m: nibble<->word adapter framed by the 2-bit cycle counter (RX assembles, TX serialises).
// Optional counter checker enabled by defining IDLI_NIBW_CHK_EN; otherwise o_ctr_err is tied low.
module idli_nibw_m #(
  parameter int NIB_W = 4
) (
  input  logic               i_ctrl_gck,
  input  logic               i_ctrl_rst_n,
  input  logic [1:0]         i_ctr,
  input  logic               i_ctr_last_cycle,
  input  logic               i_rx_nib_vld,
  input  logic [NIB_W-1:0]   i_rx_nib,
  output logic               o_rx_word_vld,
  input  logic               i_rx_word_rdy,
  output logic [4*NIB_W-1:0] o_rx_word,
  output logic               o_rx_err,
  input  logic               i_tx_word_vld,
  output logic               o_tx_word_rdy,
  input  logic [4*NIB_W-1:0] i_tx_word,
  output logic               o_tx_nib_vld,
  output logic [NIB_W-1:0]   o_tx_nib,
  output logic               o_ctr_err
);
  localparam int W = 4 * NIB_W;
  typedef enum logic [1:0] {RX_IDLE, RX_FILL, RX_HOLD} rx_st_e;
  typedef enum logic [1:0] {TX_IDLE, TX_ARMED, TX_SEND} tx_st_e;
  rx_st_e         rx_st_q, rx_st_d;
  logic [W-1:0]   rx_word_q, rx_word_d;
  logic           rx_err_q, rx_err_d;
  tx_st_e         tx_st_q, tx_st_d;
  logic [W-1:0]   tx_word_q, tx_word_d;
  logic           rx_sof, tx_acc;
  assign rx_sof = i_rx_nib_vld && i_ctr == 2'd0;
  assign tx_acc = i_tx_word_vld && o_tx_word_rdy;
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_word_d = rx_word_q;
    rx_err_d  = 1'b0;
    case (rx_st_q)
      RX_IDLE: if (rx_sof) begin
        rx_word_d[NIB_W-1:0] = i_rx_nib;
        rx_st_d = RX_FILL;
      end
      RX_FILL: if (!i_rx_nib_vld) begin
        rx_err_d = 1'b1;
        rx_st_d  = RX_IDLE;
      end else begin
        rx_word_d[i_ctr*NIB_W +: NIB_W] = i_rx_nib;
        rx_st_d = i_ctr == 2'd3 ? RX_HOLD : RX_FILL;
      end
      RX_HOLD: if (i_rx_word_rdy) begin
        rx_st_d = rx_sof ? RX_FILL : RX_IDLE;
        if (rx_sof) rx_word_d[NIB_W-1:0] = i_rx_nib;
      end else begin
        rx_err_d = rx_sof;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end
  // A word handshaken at ctr==3 of SEND re-arms so its nibble 0 follows with no gap.
  always_comb begin
    tx_st_d   = tx_st_q;
    tx_word_d = tx_acc ? i_tx_word : tx_word_q;
    case (tx_st_q)
      TX_IDLE:  tx_st_d = tx_acc ? TX_ARMED : TX_IDLE;
      TX_ARMED: tx_st_d = i_ctr == 2'd0 ? TX_SEND : TX_ARMED;
      TX_SEND:  tx_st_d = i_ctr != 2'd3 ? TX_SEND : tx_acc ? TX_ARMED : TX_IDLE;
      default:  tx_st_d = TX_IDLE;
    endcase
  end
  always_ff @(posedge i_ctrl_gck or negedge i_ctrl_rst_n) begin
    if (!i_ctrl_rst_n) begin
      rx_st_q   <= RX_IDLE;
      rx_word_q <= '0;
      rx_err_q  <= 1'b0;
      tx_st_q   <= TX_IDLE;
      tx_word_q <= '0;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_word_q <= rx_word_d;
      rx_err_q  <= rx_err_d;
      tx_st_q   <= tx_st_d;
      tx_word_q <= tx_word_d;
    end
  end
  assign o_rx_word_vld = rx_st_q == RX_HOLD;
  assign o_rx_word     = rx_word_q;
  assign o_rx_err      = rx_err_q;
  assign o_tx_word_rdy = tx_st_q == TX_IDLE || (tx_st_q == TX_SEND && i_ctr == 2'd3);
  assign o_tx_nib_vld  = tx_st_q == TX_SEND || (tx_st_q == TX_ARMED && i_ctr == 2'd0);
  assign o_tx_nib      = o_tx_nib_vld ? tx_word_q[i_ctr*NIB_W +: NIB_W] : '0;
`ifdef IDLI_NIBW_CHK_EN
  logic       chk_arm_q;
  logic [1:0] ctr_prev_q;
  logic       ctr_err_q, ctr_err_d;
  // The increment check needs one sampled counter value, so the first cycle after reset is exempt.
  always_comb begin
    ctr_err_d = ctr_err_q || (i_ctr_last_cycle != (i_ctr == 2'd3)) ||
                (chk_arm_q && i_ctr != ctr_prev_q + 2'd1);
  end
  always_ff @(posedge i_ctrl_gck or negedge i_ctrl_rst_n) begin
    if (!i_ctrl_rst_n) begin
      chk_arm_q  <= 1'b0;
      ctr_prev_q <= 2'd0;
      ctr_err_q  <= 1'b0;
    end else begin
      chk_arm_q  <= 1'b1;
      ctr_prev_q <= i_ctr;
      ctr_err_q  <= ctr_err_d;
    end
  end
  assign o_ctr_err = ctr_err_q;
`else
  logic unused_last;
  assign unused_last = i_ctr_last_cycle;
  assign o_ctr_err   = 1'b0;
`endif
endmodule

// File: tb/tb_idli_nibw_m.sv
// tb_idli_nibw_m: directed frames plus random traffic against a cycle-scheduled reference model.
module tb_idli_nibw_m;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ctr = 2'd0;
  logic        last = 1'b0;
  logic        rx_nib_vld = 1'b0, rx_word_rdy = 1'b0, tx_word_vld = 1'b0;
  logic [3:0]  rx_nib = '0;
  logic [15:0] tx_word = '0;
  logic        rx_word_vld, rx_err, tx_word_rdy, tx_nib_vld, ctr_err;
  logic [15:0] rx_word;
  logic [3:0]  tx_nib;
  idli_nibw_m #(.NIB_W(4)) dut (
    .i_ctrl_gck(clk), .i_ctrl_rst_n(rst_n), .i_ctr(ctr), .i_ctr_last_cycle(last),
    .i_rx_nib_vld(rx_nib_vld), .i_rx_nib(rx_nib), .o_rx_word_vld(rx_word_vld),
    .i_rx_word_rdy(rx_word_rdy), .o_rx_word(rx_word), .o_rx_err(rx_err),
    .i_tx_word_vld(tx_word_vld), .o_tx_word_rdy(tx_word_rdy), .i_tx_word(tx_word),
    .o_tx_nib_vld(tx_nib_vld), .o_tx_nib(tx_nib), .o_ctr_err(ctr_err)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  typedef struct { longint s; logic [15:0] w; } txw_t;
  txw_t        txq[$];
  longint      t = 0, tx_end = -1;
  int          cyc = 0, rx_cnt = 0;
  logic [15:0] rx_acc = '0, rx_hw = '0;
  bit          rx_held = 0, rx_errx = 0, exp_cerr = 0;
  bit          seen_vld, seen_rdy;
  logic [3:0]  seen_nib;
  function automatic void model_reset();
    txq.delete();
    tx_end = -1; rx_cnt = 0; rx_held = 0; rx_errx = 0; cyc = 0;
  endfunction
  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_vld"}, rx_word_vld, 0);
    check({tag, "_rx_word"}, rx_word, 0);
    check({tag, "_rx_err"}, rx_err, 0);
    check({tag, "_tx_vld"}, tx_nib_vld, 0);
    check({tag, "_tx_nib"}, tx_nib, 0);
    check({tag, "_tx_rdy"}, tx_word_rdy, 1);
    check({tag, "_ctr_err"}, ctr_err, 0);
  endtask
  // One cycle: drive at the falling edge, check, then advance the model; returns at the next falling edge.
  task automatic step(input bit rv, input logic [3:0] rn, input bit rr, input bit tv, input logic [15:0] tw);
    logic [1:0] c;
    bit erdy, etv, sof, nerr;
    logic [3:0] etn;
    longint s;
    c = 2'(cyc % 4);
    ctr = c; last = (c == 2'd3);
    rx_nib_vld = rv; rx_nib = rn; rx_word_rdy = rr; tx_word_vld = tv; tx_word = tw;
    #1;
    while (txq.size() > 0 && txq[0].s + 3 < t) void'(txq.pop_front());
    erdy = t >= tx_end; etv = 0; etn = '0;
    foreach (txq[i]) if (t >= txq[i].s && t <= txq[i].s + 3) begin
      etv = 1;
      etn = 4'(txq[i].w >> (4 * (t - txq[i].s)));
    end
    seen_vld = tx_nib_vld; seen_nib = tx_nib; seen_rdy = tx_word_rdy;
    check("tx_rdy", tx_word_rdy, erdy);
    check("tx_vld", tx_nib_vld, etv);
    check("tx_nib", tx_nib, etn);
    check("rx_vld", rx_word_vld, rx_held);
    if (rx_held) check("rx_word", rx_word, rx_hw);
    check("rx_err", rx_err, rx_errx);
    check("ctr_err", ctr_err, exp_cerr);
    if (tv && erdy) begin
      s = t + 4 - c;
      txq.push_back('{s, tw});
      tx_end = s + 3;
    end
    sof = rv && c == 2'd0; nerr = 0;
    if (rx_held) begin
      if (rr) begin
        rx_held = 0;
        if (sof) begin rx_cnt = 1; rx_acc = 16'(rn); end
      end else if (sof) nerr = 1;
    end else if (rx_cnt == 0) begin
      if (sof) begin rx_cnt = 1; rx_acc = 16'(rn); end
    end else if (!rv) begin
      rx_cnt = 0; nerr = 1;
    end else begin
      rx_acc = rx_acc | (16'(rn) << (4 * c));
      rx_cnt++;
      if (rx_cnt == 4) begin rx_held = 1; rx_hw = rx_acc; rx_cnt = 0; end
    end
    rx_errx = nerr;
    cyc++; t++;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 4'h0, 1, 0, 16'h0);
  endtask
  initial begin
    logic [31:0] seq;
    logic [7:0]  rdys;
    int          vlds;
    #3 check_reset_outputs("por");
    @(negedge clk);
    check_reset_outputs("por_clk");
    rst_n = 1'b1;
    model_reset();
    step(1, 4'h4, 1, 0, 0); step(1, 4'h3, 1, 0, 0); step(1, 4'h2, 1, 0, 0); step(1, 4'h1, 1, 0, 0);
    #1 check("w1234_vld", rx_word_vld, 1);
    check("w1234", rx_word, 16'h1234);
    idle(1);
    #1 check("w1234_once", rx_word_vld, 0);
    idle(3);
    step(1, 4'h5, 1, 0, 0); step(1, 4'h6, 1, 0, 0); idle(1);
    #1 check("abort_err", rx_err, 1);
    check("abort_novld", rx_word_vld, 0);
    idle(1);
    step(1, 4'h5, 1, 0, 0); step(1, 4'h6, 1, 0, 0); step(1, 4'h7, 1, 0, 0); step(1, 4'h8, 1, 0, 0);
    #1 check("w8765", rx_word, 16'h8765);
    idle(4);
    step(1, 4'h1, 0, 0, 0); step(1, 4'h2, 0, 0, 0); step(1, 4'h3, 0, 0, 0); step(1, 4'h4, 0, 0, 0);
    step(1, 4'h9, 0, 0, 0);
    #1 check("ovr_err", rx_err, 1);
    check("ovr_keep", rx_word, 16'h4321);
    for (int k = 0; k < 3; k++) step(1, 4'(k + 10), 0, 0, 0);
    #1 check("ovr_hold", rx_word, 16'h4321);
    idle(1);
    #1 check("ovr_done", rx_word_vld, 0);
    idle(2);
    step(0, 4'h0, 1, 1, 16'hABCD);
    seq = '0; rdys = '0; vlds = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 4'h0, 1, k < 4, 16'h5678);
      seq = {seen_nib, seq[31:4]};
      rdys[k] = seen_rdy;
      vlds += int'(seen_vld);
    end
    check("tx_seq", seq, 32'h5678ABCD);
    check("tx_nogap", vlds, 8);
    check("tx_rdy_pat", rdys, 8'h88);
    idle(1);
    step(0, 4'h0, 1, 1, 16'h1357);
    vlds = 0;
    for (int k = 0; k < 2; k++) begin
      idle(1);
      vlds += int'(seen_vld);
    end
    check("armed_quiet", vlds, 0);
    step(1, 4'hA, 1, 0, 0);
    check("armed_nib0", {seen_vld, seen_nib}, {1'b1, 4'h7});
    step(1, 4'hB, 1, 0, 0);
    check("send_nib1", {seen_vld, seen_nib}, {1'b1, 4'h5});
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    @(negedge clk);
    check_reset_outputs("mid_clk");
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3000; k++)
      step($urandom % 16 != 0, 4'($urandom), $urandom % 2 == 0, $urandom % 4 != 0, 16'($urandom));
`ifdef IDLI_NIBW_CHK_EN
    cyc--;
    exp_cerr = 1;
    idle(1);
    #1 check("ctr_err_set", ctr_err, 1);
    idle(4);
    #1 check("ctr_err_sticky", ctr_err, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
